// File: rtl/config_chain_driver_pkg.sv
// -----------------------------------------------------------------------------
// config_chain_driver_pkg
// Shared definitions for the configuration latch chain driver: the controller
// state encoding and the width helpers used to size the slot and bit counters.
// No ports (package).
// -----------------------------------------------------------------------------
package config_chain_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_WORD = 3'd1,
    ST_SETUP     = 3'd2,
    ST_PHI1      = 3'd3,
    ST_GAP       = 3'd4,
    ST_PHI2      = 3'd5,
    ST_DONE      = 3'd6
  } chain_state_t;

  // Slot down-counter holds PULSE_CYCLES-1; a single-cycle slot still needs
  // a one-bit register so the counter never collapses to zero width.
  function automatic int slot_cnt_w(input int pulse_cycles);
    return (pulse_cycles > 1) ? $clog2(pulse_cycles) : 1;
  endfunction

  // Width able to hold every value from 0 up to and including max_count.
  function automatic int bit_cnt_w(input int max_count);
    return (max_count > 0) ? $clog2(max_count + 1) : 1;
  endfunction

endpackage

// File: rtl/config_chain_driver_phase_gen.sv
// -----------------------------------------------------------------------------
// conf_phase_gen
// Timing-slot counter and strobe decode for the chain driver. Every timed state
// (SETUP, PHI1, GAP, PHI2) lasts PULSE_CYCLES clocks; o_slot_end flags the last
// clock of the current slot. Strobes are registered from the current state, so
// they trail the state by one clock, matching the registered CONF_DATA.
//
// Ports:
//   i_clk       system clock
//   i_rst       synchronous active-high reset
//   i_state     current controller state
//   o_slot_end  last clock of the current timed slot (combinational)
//   o_phi1      registered phase-1 strobe
//   o_phi2      registered phase-2 strobe
// -----------------------------------------------------------------------------
module conf_phase_gen
  import config_chain_driver_pkg::*;
#(
  parameter int PULSE_CYCLES = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  chain_state_t i_state,
  output logic         o_slot_end,
  output logic         o_phi1,
  output logic         o_phi2
);

  localparam int SW = slot_cnt_w(PULSE_CYCLES);
  localparam logic [SW-1:0] SLOT_LOAD = SW'(PULSE_CYCLES - 1);

  logic [SW-1:0] r_slot;
  logic          r_phi1;
  logic          r_phi2;
  logic          w_timed;

  assign w_timed    = (i_state == ST_SETUP) || (i_state == ST_PHI1) ||
                      (i_state == ST_GAP)   || (i_state == ST_PHI2);
  assign o_slot_end = w_timed && (r_slot == '0);

  // Counter sits preloaded outside the timed states so the first SETUP slot
  // after a word is accepted is already full length.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_slot <= SLOT_LOAD;
      r_phi1 <= 1'b0;
      r_phi2 <= 1'b0;
    end else begin
      if (!w_timed || o_slot_end) begin
        r_slot <= SLOT_LOAD;
      end else begin
        r_slot <= r_slot - SW'(1);
      end
      r_phi1 <= (i_state == ST_PHI1);
      r_phi2 <= (i_state == ST_PHI2);
    end
  end

  assign o_phi1 = r_phi1;
  assign o_phi2 = r_phi2;

endmodule

// File: rtl/config_chain_driver.sv
// -----------------------------------------------------------------------------
// config_chain_driver
// Serialises host configuration words MSB-first onto a two-phase latch chain.
// Each bit takes four slots: SETUP (data presented), PHI1 strobe, GAP, PHI2
// strobe. A frame shifts exactly CHAIN_LEN bits; the tail of the last word
// beyond CHAIN_LEN is discarded.
//
// Ports:
//   CLK         system clock
//   RESET       synchronous active-high reset
//   start       single-cycle frame request (honoured only in IDLE)
//   data_in     host word
//   data_valid  data_in valid
//   data_ready  word accepted this cycle when data_valid is high
//   CONF_DATA   serial data to chain CONFin (registered)
//   CONF_PHI1   phase-1 strobe (registered)
//   CONF_PHI2   phase-2 strobe (registered)
//   busy        frame in progress (registered)
//   done        one-cycle frame-complete pulse (registered)
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | no frame; waits for start
// WAIT_WORD | frame open, waiting for a host word (strobes low)
// SETUP     | present current MSB on CONF_DATA
// PHI1      | phase-1 strobe high
// GAP       | both strobes low, non-overlap guard
// PHI2      | phase-2 strobe high; bit retired on exit
// DONE      | frame complete, done pulse issued
// -----------------------------------------------------------------------------
module config_chain_driver
  import config_chain_driver_pkg::*;
#(
  parameter int WORD_WIDTH   = 32,
  parameter int CHAIN_LEN    = 128,
  parameter int PULSE_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  CONF_DATA,
  output logic                  CONF_PHI1,
  output logic                  CONF_PHI2,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = bit_cnt_w(CHAIN_LEN);
  localparam int LW = bit_cnt_w(WORD_WIDTH);

  chain_state_t          r_state;
  chain_state_t          w_state_nxt;
  logic [WORD_WIDTH-1:0] r_shreg;
  logic [BW-1:0]         r_bits_sent;
  logic [LW-1:0]         r_bits_left;
  logic                  r_conf_data;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_slot_end;
  logic                  w_accept;
  logic                  w_bit_exit;
  logic                  w_last_bit;
  logic                  w_word_empty;
  logic [31:0]           w_remaining;
  logic [LW-1:0]         w_load_len;

  assign data_ready   = (r_state == ST_WAIT_WORD);
  assign w_accept     = data_ready && data_valid;
  assign w_bit_exit   = (r_state == ST_PHI2) && w_slot_end;
  // Decisions on PHI2 exit look at the counters before they are updated.
  assign w_last_bit   = (r_bits_sent == BW'(CHAIN_LEN - 1));
  assign w_word_empty = (r_bits_left == LW'(1));

  // Bits still owed to the chain; caps the load so a final partial word only
  // contributes its upper bits.
  assign w_remaining  = 32'(CHAIN_LEN) - 32'(r_bits_sent);
  assign w_load_len   = (w_remaining >= 32'(WORD_WIDTH)) ? LW'(WORD_WIDTH)
                                                         : LW'(w_remaining);

  conf_phase_gen #(
    .PULSE_CYCLES (PULSE_CYCLES)
  ) u_phase_gen (
    .i_clk      (CLK),
    .i_rst      (RESET),
    .i_state    (r_state),
    .o_slot_end (w_slot_end),
    .o_phi1     (CONF_PHI1),
    .o_phi2     (CONF_PHI2)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (start)      w_state_nxt = ST_WAIT_WORD;
      ST_WAIT_WORD: if (w_accept)   w_state_nxt = ST_SETUP;
      ST_SETUP:     if (w_slot_end) w_state_nxt = ST_PHI1;
      ST_PHI1:      if (w_slot_end) w_state_nxt = ST_GAP;
      ST_GAP:       if (w_slot_end) w_state_nxt = ST_PHI2;
      ST_PHI2: begin
        if (w_slot_end) begin
          if (w_last_bit) begin
            w_state_nxt = ST_DONE;
          end else if (w_word_empty) begin
            w_state_nxt = ST_WAIT_WORD;
          end else begin
            w_state_nxt = ST_SETUP;
          end
        end
      end
      ST_DONE:      w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_shreg     <= '0;
      r_bits_sent <= '0;
      r_bits_left <= '0;
      r_conf_data <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && start) begin
        r_bits_sent <= '0;
      end

      if (w_accept) begin
        r_shreg     <= data_in;
        r_bits_left <= w_load_len;
      end else if (w_bit_exit) begin
        r_shreg     <= {r_shreg[WORD_WIDTH-2:0], 1'b0};
        r_bits_sent <= r_bits_sent + BW'(1);
        r_bits_left <= r_bits_left - LW'(1);
      end

      // CONF_DATA only moves in SETUP and otherwise holds the last bit, so
      // the head latch keeps its value across stalls and after the frame.
      if (r_state == ST_SETUP) begin
        r_conf_data <= r_shreg[WORD_WIDTH-1];
      end

      r_busy <= (r_state == ST_WAIT_WORD) || (r_state == ST_SETUP) ||
                (r_state == ST_PHI1)      || (r_state == ST_GAP)   ||
                (r_state == ST_PHI2);
      r_done <= (r_state == ST_DONE);
    end
  end

  assign CONF_DATA = r_conf_data;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_config_chain_driver.sv
module tb_config_chain_driver;

  localparam int W  = 8;
  localparam int L  = 20;
  localparam int P  = 2;
  localparam int BP = 4 * P;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         main_start = 1'b0;
  logic         noise_start = 1'b0;
  logic         start;
  logic [W-1:0] data_in = '0;
  logic         data_valid = 1'b0;
  logic         data_ready;
  logic         CONF_DATA, CONF_PHI1, CONF_PHI2, busy, done;

  assign start = main_start | noise_start;

  always #5 CLK = ~CLK;

  config_chain_driver #(
    .WORD_WIDTH   (W),
    .CHAIN_LEN    (L),
    .PULSE_CYCLES (P)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .start      (start),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .CONF_DATA  (CONF_DATA),
    .CONF_PHI1  (CONF_PHI1),
    .CONF_PHI2  (CONF_PHI2),
    .busy       (busy),
    .done       (done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 waiting for word, 2 shifting word, 3 done
  // Outputs are registered, so each edge computes them from the view held
  // before that edge, then advances the view.
  int           m_phase = 0;
  int           m_k = 0;
  int           m_nbits = 0;
  int           m_sent = 0;
  int           m_slot = 0;
  logic [W-1:0] m_word = '0;
  logic         e_data = 1'b0, e_phi1 = 1'b0, e_phi2 = 1'b0, e_busy = 1'b0, e_done = 1'b0;
  int           ecyc = 0;
  int           m_start_edge = 0;

  initial forever begin
    @(posedge CLK);
    ecyc++;
    if (RESET) begin
      e_data = 1'b0; e_phi1 = 1'b0; e_phi2 = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      m_phase = 0; m_sent = 0; m_k = 0;
    end else begin
      m_slot = (m_k % BP) / P;
      e_phi1 = (m_phase == 2) && (m_slot == 1);
      e_phi2 = (m_phase == 2) && (m_slot == 3);
      if ((m_phase == 2) && (m_slot == 0)) e_data = m_word[W-1-(m_k/BP)];
      e_busy = (m_phase == 1) || (m_phase == 2);
      e_done = (m_phase == 3);
      case (m_phase)
        0: if (start) begin m_phase = 1; m_sent = 0; m_start_edge = ecyc; end
        1: if (data_valid) begin
             m_word  = data_in;
             m_nbits = ((L - m_sent) < W) ? (L - m_sent) : W;
             m_k     = 0;
             m_phase = 2;
           end
        2: begin
             m_k++;
             if (m_k == BP * m_nbits) begin
               m_sent += m_nbits;
               m_phase = (m_sent == L) ? 3 : 1;
             end
           end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- compare process ----------------
  logic         mon_en = 1'b0;
  logic         prev_phi1 = 1'b0;
  logic         held_bit = 1'b0;
  logic [L-1:0] cap = '0;
  int           phi1_cnt = 0;
  int           first_phi1_edge = -1;
  int           done_edge = 0;
  int           done_cnt = 0;

  initial forever begin
    @(negedge CLK);
    if (mon_en) begin
      chk("conf_data",  {31'd0, CONF_DATA},  {31'd0, e_data});
      chk("conf_phi1",  {31'd0, CONF_PHI1},  {31'd0, e_phi1});
      chk("conf_phi2",  {31'd0, CONF_PHI2},  {31'd0, e_phi2});
      chk("busy",       {31'd0, busy},       {31'd0, e_busy});
      chk("done",       {31'd0, done},       {31'd0, e_done});
      chk("data_ready", {31'd0, data_ready}, {31'd0, (m_phase == 1)});
      chk("no_overlap", {31'd0, CONF_PHI1 & CONF_PHI2}, 32'd0);
      if (CONF_PHI1 && !prev_phi1) begin
        cap = {cap[L-2:0], CONF_DATA};
        phi1_cnt++;
        if (first_phi1_edge < 0) first_phi1_edge = ecyc;
        held_bit = CONF_DATA;
      end
      if (CONF_PHI2) chk("data_stable", {31'd0, CONF_DATA}, {31'd0, held_bit});
      if (done) begin done_edge = ecyc; done_cnt++; end
      prev_phi1 = CONF_PHI1;
    end
  end

  // ---------------- host feeder ----------------
  logic [W-1:0] host_q[$];
  int           stall_min = 0, stall_max = 0, stall_left = 0;
  logic         acc_pending = 1'b0;

  initial forever begin
    @(negedge CLK);
    #2;
    if (acc_pending) begin
      if (host_q.size() > 0) void'(host_q.pop_front());
      acc_pending = 1'b0;
      stall_left = int'($urandom_range(stall_max, stall_min));
    end
    if (stall_left > 0) begin
      stall_left--;
      data_valid = 1'b0;
      data_in = W'($urandom);
    end else if (host_q.size() > 0) begin
      data_valid = 1'b1;
      data_in = host_q[0];
    end else begin
      data_valid = 1'b0;
      data_in = W'($urandom);
    end
    acc_pending = data_valid && data_ready && !RESET;
  end

  // Spurious start requests, only while a frame is open.
  logic noise_en = 1'b0;
  initial forever begin
    @(negedge CLK);
    #1;
    noise_start = noise_en && (m_phase != 0) && ($urandom_range(7, 0) == 0);
  end

  // ---------------- helpers ----------------
  task automatic pulse_start();
    @(negedge CLK);
    main_start = 1'b1;
    @(negedge CLK);
    main_start = 1'b0;
  endtask

  task automatic clear_frame_stats();
    cap = '0; phi1_cnt = 0; first_phi1_edge = -1; done_cnt = 0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while ((done !== 1'b1) && (n < limit)) begin
      @(negedge CLK);
      n++;
    end
    chk("done_timeout", {31'd0, (n < limit)}, 32'd1);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge CLK);
  endtask

  task automatic push_random_frame();
    for (int i = 0; i < 3; i++) host_q.push_back(W'($urandom));
  endtask

  task automatic run_directed();
    stall_min = 0; stall_max = 0;
    host_q = '{8'hA5, 8'h3C, 8'hF0};
    repeat (5) @(negedge CLK);
    chk("no_consume_idle", host_q.size(), 32'd3);
    clear_frame_stats();
    pulse_start();
    wait_done(400);
    chk("bit_sequence",  {12'd0, cap}, 32'h000A53CF);
    chk("phi1_count",    phi1_cnt, 32'd20);
    chk("phi1_latency",  first_phi1_edge - m_start_edge, 32'd4);
    chk("done_latency",  done_edge - m_start_edge, 32'd164);
    chk("done_pulses",   done_cnt, 32'd1);
    chk("words_used",    host_q.size(), 32'd0);
    chk("data_hold",     {31'd0, CONF_DATA}, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    RESET = 1'b1;
    @(negedge CLK);
    mon_en = 1'b1;
    repeat (2) @(negedge CLK);
    chk("reset_outputs",
        {26'd0, CONF_DATA, CONF_PHI1, CONF_PHI2, busy, done, data_ready}, 32'd0);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // Directed frame with data_valid high in IDLE before start.
    run_directed();

    // Long host stalls between words with spurious starts.
    stall_min = 20; stall_max = 20;
    noise_en = 1'b1;
    push_random_frame();
    clear_frame_stats();
    pulse_start();
    wait_done(1000);
    chk("stall_phi1_count", phi1_cnt, 32'd20);
    chk("stall_done_pulses", done_cnt, 32'd1);

    // Random frames with random stalls and spurious starts.
    for (int f = 0; f < 6; f++) begin
      stall_min = 0; stall_max = 4;
      push_random_frame();
      clear_frame_stats();
      repeat (int'($urandom_range(3, 0))) @(negedge CLK);
      pulse_start();
      wait_done(800);
      chk("rand_phi1_count", phi1_cnt, 32'd20);
      chk("rand_done_pulses", done_cnt, 32'd1);
    end
    noise_en = 1'b0;

    // Reset during PHI1 of bit 5, then a clean frame must match the directed one.
    stall_min = 0; stall_max = 0;
    push_random_frame();
    clear_frame_stats();
    pulse_start();
    n = 0;
    while ((phi1_cnt < 6) && (n < 200)) begin
      @(negedge CLK);
      n++;
    end
    chk("bit5_timeout", {31'd0, (n < 200)}, 32'd1);
    chk("in_phi1", {31'd0, CONF_PHI1}, 32'd1);
    #1;
    RESET = 1'b1;
    @(negedge CLK);
    chk("abort_outputs",
        {26'd0, CONF_DATA, CONF_PHI1, CONF_PHI2, busy, done, data_ready}, 32'd0);
    #1;
    RESET = 1'b0;
    host_q.delete();
    repeat (3) @(negedge CLK);
    chk("idle_after_abort", {31'd0, busy}, 32'd0);
    run_directed();

    repeat (4) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
